mux_arbiter4: RTL and testbench



---
 rtl/mux_arbiter4_pkg.sv | 13 +
 rtl/mux_arbiter4_rr_arb4.sv | 32 +++
 rtl/mux_arbiter4.sv | 75 +++++++
 tb/tb_mux_arbiter4.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arbiter4_pkg.sv
// mux_pkg: shared widths, channel count, arbitration modes and FSM encoding for mux_arbiter4.
package mux_pkg;
  localparam int DATA_W = 12;
  localparam int NUM_CH = 4;
  localparam int CLASS_W = 2;
  localparam int ARB_RR = 0;
  localparam int ARB_FIXED = 1;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    PAUSE  = 2'b10
  } state_t;
endpackage

// File: rtl/mux_arbiter4_rr_arb4.sv
// rr_arb4: 4-way round-robin / fixed-priority arbiter with registered last-grant pointer.
module rr_arb4
  import mux_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_CH-1:0]  req_i,
  input  logic               enable_i,
  input  logic               mode_i,
  output logic [NUM_CH-1:0]  grant_o,
  output logic [CLASS_W-1:0] idx_o
);
  logic [CLASS_W-1:0] last_q, last_d, cand;
  logic found;
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = mode_i ? CLASS_W'(i) : last_q + CLASS_W'(i + 1);
      if (enable_i && !found && req_i[cand]) begin
        found = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o = cand;
      end
    end
  end
  assign last_d = found ? idx_o : last_q;
  // Pointer resets to the last channel so the search begins at ch0.
  always_ff @(posedge clk) last_q <= reset ? CLASS_W'(NUM_CH - 1) : last_d;
endmodule

// File: rtl/mux_arbiter4.sv
// mux_arbiter4: merges four show-ahead class FIFOs into one tagged stream, honouring downstream almost-full.
module mux_arbiter4
  import mux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic                  empty2,
  input  logic                  empty3,
  input  logic                  pause,
  output logic                  pop_0,
  output logic                  pop_1,
  output logic                  pop_2,
  output logic                  pop_3,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CLASS_W-1:0]    class_o,
  output logic                  push,
  output logic                  active
);
  state_t state_q, state_d;
  logic [NUM_CH-1:0] req, grant;
  logic [CLASS_W-1:0] idx, class_q;
  logic [DATA_WIDTH-1:0] sel, data_q;
  logic any_req, en, push_q, active_q;
  assign req = ~{empty3, empty2, empty1, empty0};
  assign any_req = |req;
  // Pause gates the grant in the same cycle; reset gates it so no FIFO is popped while held.
  assign en = !reset && state_q == ACTIVE && !pause;
  rr_arb4 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .enable_i(en),
    .mode_i  (ARB_MODE == ARB_FIXED),
    .grant_o (grant),
    .idx_o   (idx)
  );
  assign {pop_3, pop_2, pop_1, pop_0} = grant;
  always_comb sel = idx == 2'd0 ? data_in0 : idx == 2'd1 ? data_in1 : idx == 2'd2 ? data_in2 : data_in3;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (any_req && !pause) ? ACTIVE : IDLE;
    else if (pause) state_d = PAUSE;
    else state_d = any_req ? ACTIVE : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      active_q <= 1'b0;
      push_q <= 1'b0;
      data_q <= '0;
      class_q <= '0;
    end else begin
      state_q <= state_d;
      active_q <= state_d == ACTIVE;
      push_q <= |grant;
      if (|grant) begin
        data_q <= sel;
        class_q <= idx;
      end
    end
  end
  assign data_out = data_q;
  assign class_o = class_q;
  assign push = push_q;
  assign active = active_q;
endmodule

// File: tb/tb_mux_arbiter4.sv
// tb_mux_arbiter4: FIFO-model driven scoreboard bench for both arbitration modes of mux_arbiter4.
module tb_mux_arbiter4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;
  logic mode_sel = 1'b0;
  logic [11:0] din[4];
  logic [3:0] emp;
  wire [3:0] pop_r, pop_f;
  wire [11:0] dout_r, dout_f;
  wire [1:0] cls_r, cls_f;
  wire push_r, push_f, act_r, act_f;
  wire [3:0] pop = mode_sel ? pop_f : pop_r;
  wire [11:0] dout = mode_sel ? dout_f : dout_r;
  wire [1:0] cls = mode_sel ? cls_f : cls_r;
  wire push = mode_sel ? push_f : push_r;
  wire act = mode_sel ? act_f : act_r;
  logic [11:0] fq[4][$];
  logic [13:0] sb[$];
  logic [1:0] obs_cls[$];
  logic [3:0] s_pop;
  logic s_push, s_act;
  logic [11:0] s_data;
  logic [1:0] s_cls;
  int n_chk = 0;
  int n_fail = 0;
  int ncyc = 0;

  always #5 clk = ~clk;

  mux_arbiter4 #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .empty0(emp[0]), .empty1(emp[1]), .empty2(emp[2]), .empty3(emp[3]),
    .pause(pause),
    .pop_0(pop_r[0]), .pop_1(pop_r[1]), .pop_2(pop_r[2]), .pop_3(pop_r[3]),
    .data_out(dout_r), .class_o(cls_r), .push(push_r), .active(act_r)
  );

  mux_arbiter4 #(.ARB_MODE(1)) dut_fx (
    .clk(clk), .reset(reset),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .empty0(emp[0]), .empty1(emp[1]), .empty2(emp[2]), .empty3(emp[3]),
    .pause(pause),
    .pop_0(pop_f[0]), .pop_1(pop_f[1]), .pop_2(pop_f[2]), .pop_3(pop_f[3]),
    .data_out(dout_f), .class_o(cls_f), .push(push_f), .active(act_f)
  );

  task automatic refresh();
    for (int c = 0; c < 4; c++) begin
      emp[c] = fq[c].size() == 0;
      din[c] = (fq[c].size() != 0) ? fq[c][0] : 12'h000;
    end
  endtask

  task automatic load(input int ch, input int n, input logic [11:0] base);
    for (int k = 0; k < n; k++) fq[ch].push_back(base + 12'(k));
    refresh();
  endtask

  // One clock: sample/check at negedge, then retire popped heads just after posedge.
  task automatic cycle();
    logic [13:0] exp;
    @(negedge clk);
    s_pop = pop; s_push = push; s_data = dout; s_cls = cls; s_act = act;
    if (push === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL push_unexpected: got class %0d data %h, expected no push", cls, dout);
      end else begin
        exp = sb.pop_front();
        if ({cls, dout} !== exp)
          begin n_fail++; $display("FAIL push_word: got class %0d data %h, expected class %0d data %h", cls, dout, exp[13:12], exp[11:0]); end
      end
      obs_cls.push_back(cls);
    end
    n_chk++;
    if (!$onehot0(pop)) begin n_fail++; $display("FAIL pop_onehot: got pops %b, expected at most one", pop); end
    for (int c = 0; c < 4; c++) if (pop[c] === 1'b1) begin
      n_chk++;
      if (fq[c].size() == 0) begin n_fail++; $display("FAIL pop_empty: got pop on ch%0d, expected none (empty)", c); end
      else sb.push_back({2'(c), fq[c][0]});
    end
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) if (s_pop[c] === 1'b1 && fq[c].size() != 0) void'(fq[c].pop_front());
    refresh();
    ncyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
    obs_cls.delete();
  endtask

  task automatic drain();
    int k = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() != 0 || sb.size() != 0 || push === 1'b1) && k < 200) begin
      cycle();
      k++;
    end
    n_chk++;
    if (k >= 200) begin n_fail++; $display("FAIL drain_timeout: got %0d words left, expected 0", sb.size()); end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) load(c, 1, 12'(256 * (c + 1)));
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      n_chk++;
      if ({s_pop, s_push, s_data, s_cls, s_act} !== 20'h0)
        begin n_fail++; $display("FAIL reset_outputs: got pop %b push %b data %h class %0d active %b, expected all 0", s_pop, s_push, s_data, s_cls, s_act); end
    end
    reset = 1'b0;
    cycle();
    n_chk++;
    if (s_pop !== 4'b0000) begin n_fail++; $display("FAIL reset_idle_cycle: got pops %b, expected 0000", s_pop); end
    cycle();
    n_chk++;
    if (s_pop !== 4'b0001) begin n_fail++; $display("FAIL reset_first_pop: got pops %b, expected 0001", s_pop); end
    drain();
  endtask

  task automatic test_single();
    logic [3:0] mask = '0;
    do_reset(1);
    load(2, 1, 12'hABC);
    cycle();
    mask |= s_pop;
    n_chk++;
    if (s_pop !== 4'b0000) begin n_fail++; $display("FAIL single_idle: got pops %b, expected 0000", s_pop); end
    cycle();
    mask |= s_pop;
    n_chk++;
    if (s_pop !== 4'b0100) begin n_fail++; $display("FAIL single_pop: got pops %b, expected 0100", s_pop); end
    cycle();
    mask |= s_pop;
    n_chk++;
    if ({s_push, s_cls, s_data} !== {1'b1, 2'd2, 12'hABC})
      begin n_fail++; $display("FAIL single_push: got push %b class %0d data %h, expected 1 2 abc", s_push, s_cls, s_data); end
    repeat (3) begin cycle(); mask |= s_pop; end
    n_chk++;
    if (mask !== 4'b0100) begin n_fail++; $display("FAIL single_other_pops: got pop mask %b, expected 0100", mask); end
    n_chk++;
    if (obs_cls.size() != 1) begin n_fail++; $display("FAIL single_push_count: got %0d, expected 1", obs_cls.size()); end
  endtask

  task automatic test_rr();
    int first = -1, last = -1, k = 0;
    logic mid_act = 1'b0;
    mode_sel = 1'b0;
    do_reset(1);
    for (int c = 0; c < 4; c++) load(c, 3, 12'(c * 16));
    while (obs_cls.size() < 12 && k < 40) begin
      cycle();
      k++;
      if (s_push === 1'b1) begin
        if (first < 0) first = ncyc;
        last = ncyc;
        if (obs_cls.size() == 6) mid_act = s_act;
      end
    end
    n_chk++;
    if (obs_cls.size() != 12) begin n_fail++; $display("FAIL rr_count: got %0d pushes, expected 12", obs_cls.size()); end
    for (int i = 0; i < obs_cls.size(); i++) begin
      n_chk++;
      if (obs_cls[i] !== 2'(i % 4)) begin n_fail++; $display("FAIL rr_order[%0d]: got class %0d, expected %0d", i, obs_cls[i], i % 4); end
    end
    n_chk++;
    if (last - first != 11) begin n_fail++; $display("FAIL rr_back_to_back: got span %0d, expected 11", last - first); end
    n_chk++;
    if (mid_act !== 1'b1) begin n_fail++; $display("FAIL rr_active_mid: got %b, expected 1", mid_act); end
    drain();
    cycle();
    n_chk++;
    if (s_act !== 1'b0) begin n_fail++; $display("FAIL rr_active_fall: got %b, expected 0", s_act); end
  endtask

  task automatic test_fixed();
    int k = 0;
    logic [1:0] exp_seq[4] = '{2'd0, 2'd0, 2'd3, 2'd3};
    mode_sel = 1'b1;
    do_reset(1);
    load(0, 2, 12'h0A0);
    load(3, 2, 12'h3B0);
    while (obs_cls.size() < 4 && k < 20) begin cycle(); k++; end
    n_chk++;
    if (obs_cls.size() != 4) begin n_fail++; $display("FAIL fixed_count: got %0d pushes, expected 4", obs_cls.size()); end
    for (int i = 0; i < obs_cls.size() && i < 4; i++) begin
      n_chk++;
      if (obs_cls[i] !== exp_seq[i]) begin n_fail++; $display("FAIL fixed_order[%0d]: got class %0d, expected %0d", i, obs_cls[i], exp_seq[i]); end
    end
    drain();
    mode_sel = 1'b0;
  endtask

  task automatic test_backpressure();
    int npop = 0, k = 0, base;
    logic [3:0] mask = '0;
    mode_sel = 1'b0;
    do_reset(1);
    for (int c = 0; c < 4; c++) load(c, 3, 12'h400 + 12'(c * 16));
    while (npop < 5 && k < 30) begin cycle(); k++; npop += $countones(s_pop); end
    pause = 1'b1;
    base = obs_cls.size();
    cycle();
    n_chk++;
    if (s_pop !== 4'b0000) begin n_fail++; $display("FAIL pause_same_cycle: got pops %b, expected 0000", s_pop); end
    n_chk++;
    if ({s_push, s_cls} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL pause_trailing: got push %b class %0d, expected 1 0", s_push, s_cls); end
    cycle();
    mask |= s_pop;
    n_chk++;
    if (s_act !== 1'b0) begin n_fail++; $display("FAIL pause_state: got active %b, expected 0", s_act); end
    repeat (2) begin cycle(); mask |= s_pop; end
    n_chk++;
    if (mask !== 4'b0000) begin n_fail++; $display("FAIL pause_no_pop: got pop mask %b, expected 0000", mask); end
    n_chk++;
    if (obs_cls.size() - base != 1) begin n_fail++; $display("FAIL pause_push_count: got %0d, expected 1", obs_cls.size() - base); end
    pause = 1'b0;
    cycle();
    n_chk++;
    if (s_pop !== 4'b0000) begin n_fail++; $display("FAIL resume_gap: got pops %b, expected 0000", s_pop); end
    cycle();
    n_chk++;
    if (s_pop !== 4'b0010) begin n_fail++; $display("FAIL resume_order: got pops %b, expected 0010", s_pop); end
    drain();
  endtask

  task automatic test_reset_mid();
    int k = 0;
    mode_sel = 1'b0;
    do_reset(1);
    for (int c = 0; c < 4; c++) load(c, 2, 12'h800 + 12'(c * 16));
    while (push !== 1'b1 && k < 20) begin cycle(); k++; end
    n_chk++;
    if (push !== 1'b1) begin n_fail++; $display("FAIL midreset_wait: got push %b, expected 1", push); end
    reset = 1'b1;
    cycle();
    n_chk++;
    if ({s_pop, s_push} !== 5'b00001) begin n_fail++; $display("FAIL midreset_gate: got pops %b push %b, expected 0000 1", s_pop, s_push); end
    reset = 1'b0;
    cycle();
    n_chk++;
    if ({s_push, s_data, s_cls, s_pop} !== 19'h0)
      begin n_fail++; $display("FAIL midreset_clear: got push %b data %h class %0d pops %b, expected 0 000 0 0000", s_push, s_data, s_cls, s_pop); end
    cycle();
    n_chk++;
    if (s_pop !== 4'b0001) begin n_fail++; $display("FAIL midreset_pointer: got pops %b, expected 0001", s_pop); end
    drain();
  endtask

  initial begin
    refresh();
    test_reset();
    test_single();
    test_rr();
    test_fixed();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
